// File: rtl/sim_watchdog_pkg.sv
// sim_watchdog_pkg
//   Shared types and helpers for the end-of-simulation watchdog.
//   wd_state_e : controller state, encoded as it appears on state_o
//   wd_cause_e : terminal cause, encoded as it appears on cause_o
//   ch_w()     : width of a channel index, never less than one bit
package sim_watchdog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wd_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_HALT    = 2'd1,
    CAUSE_ERROR   = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } wd_cause_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_wd_idle_counter.sv
// sim_wd_idle_counter
//   Per-channel inactivity timer and sticky halt latch.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : arm edge; reload the timer and clear the halt latch
//   run_i        : controller is in RUN; timer and latch update
//   progress_i   : forward-progress strobe; reloads the timer
//   halt_i       : halt indication; sets the latch
//   halted_o     : latched halt (halts seen in earlier RUN cycles)
//   idle_o       : channel idles out this cycle
module sim_wd_idle_counter
  import sim_watchdog_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  input  logic progress_i,
  input  logic halt_i,
  output logic halted_o,
  output logic idle_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(IDLE_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hl_q, hl_d;

  always_comb begin
    cnt_d = cnt_q;
    hl_d  = hl_q;
    if (load_i) begin
      cnt_d = RELOAD;
      hl_d  = 1'b0;
    end else if (run_i) begin
      hl_d = hl_q | halt_i;
      if (progress_i) begin
        cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      hl_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hl_q  <= hl_d;
    end
  end

  assign halted_o = hl_q;
  // A strobe in the same cycle as the counter reaching zero still counts as
  // progress, and a channel that has halted is never considered idle.
  assign idle_o   = (IDLE_TIMEOUT != 0) && (cnt_q == '0) && !progress_i && !hl_q;

endmodule

// File: rtl/sim_watchdog.sv
// sim_watchdog
//   End-of-simulation controller: watches NUM_CH channels for progress,
//   halt and error, applies absolute and per-channel idle timeouts, drains
//   after an error and reports a single terminal cause.
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : arm, only looked at in IDLE
//   progress_i   : per-channel progress strobes
//   halt_i       : per-channel halt indications
//   error_i      : per-channel error indications
//   state_o      : current state
//   finish_o     : high while in DONE
//   cause_o      : terminal cause
//   error_o      : sticky error flag
//   err_ch_o     : lowest-index erroring channel
//   timed_out_o  : sticky absolute/idle timeout flag
//   idle_ch_o    : channels that idled out
//   cycles_o     : RUN cycles before the terminal event, saturating
//
//   state | meaning
//   IDLE  | waiting for start_i
//   RUN   | monitoring channels, counting cycles
//   DRAIN | post-error grace period, inputs ignored
//   DONE  | terminal, outputs held until reset
module sim_watchdog
  import sim_watchdog_pkg::*;
#(
  parameter int NUM_CH       = 1,
  parameter int CNT_W        = 32,
  parameter int ABS_TIMEOUT  = 10000,
  parameter int IDLE_TIMEOUT = 0,
  parameter int DRAIN_CYCLES = 5,
  parameter int HALT_ALL     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [NUM_CH-1:0]         progress_i,
  input  logic [NUM_CH-1:0]         halt_i,
  input  logic [NUM_CH-1:0]         error_i,
  output logic [1:0]                state_o,
  output logic                      finish_o,
  output logic [1:0]                cause_o,
  output logic                      error_o,
  output logic [ch_w(NUM_CH)-1:0]   err_ch_o,
  output logic                      timed_out_o,
  output logic [NUM_CH-1:0]         idle_ch_o,
  output logic [CNT_W-1:0]          cycles_o
);

  localparam int CH_W = ch_w(NUM_CH);

  if (NUM_CH < 1) begin : g_chk_num_ch
    $error("sim_watchdog: NUM_CH must be at least 1");
  end
  if (((ABS_TIMEOUT >> CNT_W) != 0) || ((IDLE_TIMEOUT >> CNT_W) != 0) ||
      ((DRAIN_CYCLES >> CNT_W) != 0)) begin : g_chk_cnt_w
    $error("sim_watchdog: CNT_W too narrow for the timeout/drain parameters");
  end

  wd_state_e         state_q, state_d;
  wd_cause_e         cause_q, cause_d;
  logic              error_q, error_d;
  logic [CH_W-1:0]   err_ch_q, err_ch_d;
  logic              timed_out_q, timed_out_d;
  logic [NUM_CH-1:0] idle_ch_q, idle_ch_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  abs_cnt_q, abs_cnt_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;

  logic              arm, running;
  logic [NUM_CH-1:0] hl_vec, idle_vec, halt_seen;
  logic              err_any, abs_ev, hlt_ev;
  logic [CH_W-1:0]   err_idx;

  assign arm     = (state_q == ST_IDLE) && start_i;
  assign running = (state_q == ST_RUN);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sim_wd_idle_counter #(
      .CNT_W        (CNT_W),
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) u_idle (
      .clk        (clk),
      .rst        (rst),
      .load_i     (arm),
      .run_i      (running),
      .progress_i (progress_i[g]),
      .halt_i     (halt_i[g]),
      .halted_o   (hl_vec[g]),
      .idle_o     (idle_vec[g])
    );
  end

  assign halt_seen = hl_vec | halt_i;
  assign hlt_ev    = (HALT_ALL != 0) ? (&halt_seen) : (|halt_seen);
  assign abs_ev    = (ABS_TIMEOUT != 0) && (abs_cnt_q == '0);

  // Written so that an unknown error_i fails the all-zero test and is
  // treated as an error in simulation.
  always_comb begin
    err_any = 1'b1;
    if (error_i == '0) begin
      err_any = 1'b0;
    end
  end

  always_comb begin
    err_idx = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (error_i[c]) begin
        err_idx = CH_W'(c);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    error_d     = error_q;
    err_ch_d    = err_ch_q;
    timed_out_d = timed_out_q;
    idle_ch_d   = idle_ch_q;
    cycles_d    = cycles_q;
    abs_cnt_d   = abs_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          abs_cnt_d = CNT_W'(ABS_TIMEOUT);
          cycles_d  = '0;
        end
      end
      ST_RUN: begin
        abs_cnt_d = (abs_cnt_q != '0) ? abs_cnt_q - CNT_W'(1) : '0;
        if (err_any) begin
          error_d     = 1'b1;
          cause_d     = CAUSE_ERROR;
          err_ch_d    = err_idx;
          drain_cnt_d = CNT_W'(DRAIN_CYCLES);
          state_d     = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
        end else if (abs_ev || (idle_vec != '0)) begin
          timed_out_d = 1'b1;
          cause_d     = CAUSE_TIMEOUT;
          idle_ch_d   = idle_vec;
          state_d     = ST_DONE;
        end else if (hlt_ev) begin
          cause_d = CAUSE_HALT;
          state_d = ST_DONE;
        end else begin
          cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // Loaded with DRAIN_CYCLES on the error edge and left at zero, so
        // DONE arrives DRAIN_CYCLES+1 edges after the error edge.
        if (drain_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      error_q     <= 1'b0;
      err_ch_q    <= '0;
      timed_out_q <= 1'b0;
      idle_ch_q   <= '0;
      cycles_q    <= '0;
      abs_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      error_q     <= error_d;
      err_ch_q    <= err_ch_d;
      timed_out_q <= timed_out_d;
      idle_ch_q   <= idle_ch_d;
      cycles_q    <= cycles_d;
      abs_cnt_q   <= abs_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always @(posedge clk) begin
    if (!rst && (state_q == ST_RUN)) begin
      assert (!$isunknown({start_i, progress_i, halt_i, error_i}));
    end
  end

  assign state_o     = state_q;
  assign finish_o    = (state_q == ST_DONE);
  assign cause_o     = cause_q;
  assign error_o     = error_q;
  assign err_ch_o    = err_ch_q;
  assign timed_out_o = timed_out_q;
  assign idle_ch_o   = idle_ch_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_sim_watchdog.sv
module tb_sim_watchdog;

  localparam int MAXK  = 64;
  localparam int LIMIT = 100;

  // Three configurations share one stimulus stream.
  localparam int ABS_T  [3] = '{10, 30, 0};
  localparam int IDLE_T [3] = '{0, 3, 4};
  localparam int DRN_T  [3] = '{5, 0, 2};
  localparam int HALL_T [3] = '{1, 0, 1};
  localparam int CMAX   [3] = '{1000000, 1000000, 15};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [1:0] progress_i = '0;
  logic [1:0] halt_i = '0;
  logic [1:0] error_i = '0;

  logic [1:0]  st    [3];
  logic        fin   [3];
  logic [1:0]  cau   [3];
  logic        erro  [3];
  logic [0:0]  errch [3];
  logic        tmo   [3];
  logic [1:0]  idlv  [3];
  logic [31:0] cyc0, cyc1;
  logic [3:0]  cyc2;

  logic [1:0] s_prog [MAXK];
  logic [1:0] s_halt [MAXK];
  logic [1:0] s_err  [MAXK];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sim_watchdog #(.NUM_CH(2), .CNT_W(32), .ABS_TIMEOUT(ABS_T[0]), .IDLE_TIMEOUT(IDLE_T[0]),
                 .DRAIN_CYCLES(DRN_T[0]), .HALT_ALL(HALL_T[0])) u_d0 (
    .clk(clk), .rst(rst), .start_i(start_i), .progress_i(progress_i), .halt_i(halt_i),
    .error_i(error_i), .state_o(st[0]), .finish_o(fin[0]), .cause_o(cau[0]), .error_o(erro[0]),
    .err_ch_o(errch[0]), .timed_out_o(tmo[0]), .idle_ch_o(idlv[0]), .cycles_o(cyc0));

  sim_watchdog #(.NUM_CH(2), .CNT_W(32), .ABS_TIMEOUT(ABS_T[1]), .IDLE_TIMEOUT(IDLE_T[1]),
                 .DRAIN_CYCLES(DRN_T[1]), .HALT_ALL(HALL_T[1])) u_d1 (
    .clk(clk), .rst(rst), .start_i(start_i), .progress_i(progress_i), .halt_i(halt_i),
    .error_i(error_i), .state_o(st[1]), .finish_o(fin[1]), .cause_o(cau[1]), .error_o(erro[1]),
    .err_ch_o(errch[1]), .timed_out_o(tmo[1]), .idle_ch_o(idlv[1]), .cycles_o(cyc1));

  sim_watchdog #(.NUM_CH(2), .CNT_W(4), .ABS_TIMEOUT(ABS_T[2]), .IDLE_TIMEOUT(IDLE_T[2]),
                 .DRAIN_CYCLES(DRN_T[2]), .HALT_ALL(HALL_T[2])) u_d2 (
    .clk(clk), .rst(rst), .start_i(start_i), .progress_i(progress_i), .halt_i(halt_i),
    .error_i(error_i), .state_o(st[2]), .finish_o(fin[2]), .cause_o(cau[2]), .error_o(erro[2]),
    .err_ch_o(errch[2]), .timed_out_o(tmo[2]), .idle_ch_o(idlv[2]), .cycles_o(cyc2));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] cyc_of(input int i);
    case (i)
      0:       return cyc0;
      1:       return cyc1;
      default: return {28'd0, cyc2};
    endcase
  endfunction

  // Reference model: walks the stimulus cycle by cycle using the event rules.
  // An idle counter reloaded by progress in cycle j reads zero from cycle
  // j+1+IDLE onward, so idle-out is a distance test against the last reload.
  function automatic void model(input int i, output int ev_k, output int cause,
                                output int ech, output int iv_o, output int fin_e);
    int         last_r [2];
    logic [1:0] hl, h, iv;
    bit         hlt;
    last_r = '{0, 0};
    hl = '0;
    ev_k = MAXK; cause = 0; ech = 0; iv_o = 0; fin_e = -1;
    for (int k = 0; k < MAXK; k++) begin
      iv = '0;
      for (int c = 0; c < 2; c++) begin
        if (IDLE_T[i] != 0 && (k - last_r[c]) >= IDLE_T[i] && !s_prog[k][c] && !hl[c])
          iv[c] = 1'b1;
      end
      h   = hl | s_halt[k];
      hlt = (HALL_T[i] != 0) ? (h == 2'b11) : (h != 2'b00);
      if (s_err[k] != 2'b00) begin
        ev_k = k; cause = 2; ech = s_err[k][0] ? 0 : 1;
        fin_e = (DRN_T[i] == 0) ? k + 1 : k + 2 + DRN_T[i];
        return;
      end
      if ((ABS_T[i] != 0 && k == ABS_T[i]) || iv != 2'b00) begin
        ev_k = k; cause = 3; iv_o = int'(iv); fin_e = k + 1;
        return;
      end
      if (hlt) begin
        ev_k = k; cause = 1; fin_e = k + 1;
        return;
      end
      hl = hl | s_halt[k];
      for (int c = 0; c < 2; c++) if (s_prog[k][c]) last_r[c] = k + 1;
    end
  endfunction

  task automatic drive(input int e);
    if (e < MAXK) begin
      progress_i = s_prog[e]; halt_i = s_halt[e]; error_i = s_err[e];
    end else begin
      progress_i = '0; halt_i = '0; error_i = '0;
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXK; k++) begin
      s_prog[k] = '0; s_halt[k] = '0; s_err[k] = '0;
    end
    s_err[MAXK-1] = 2'b01;
  endtask

  task automatic do_reset(input string name);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s d%0d rst state", name, i), 64'(st[i]), 0);
      check($sformatf("%s d%0d rst finish", name, i), 64'(fin[i]), 0);
      check($sformatf("%s d%0d rst cause", name, i), 64'(cau[i]), 0);
      check($sformatf("%s d%0d rst error", name, i), 64'(erro[i]), 0);
      check($sformatf("%s d%0d rst cycles", name, i), 64'(cyc_of(i)), 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    start_i = 1'b1; progress_i = '0; halt_i = '0; error_i = '0;
    @(posedge clk);
    #1 start_i = 1'b0;
    drive(0);
  endtask

  task automatic do_run(input string name);
    int ev_k [3], cau_e [3], ech_e [3], iv_e [3], fin_e [3], fin_seen [3], st_ev [3];
    int e, exp_cyc, exp_st;
    bit all_done;
    for (int i = 0; i < 3; i++) begin
      model(i, ev_k[i], cau_e[i], ech_e[i], iv_e[i], fin_e[i]);
      fin_seen[i] = -1; st_ev[i] = -1;
    end
    start_run();
    e = 0;
    all_done = 1'b0;
    while (!all_done && e < LIMIT) begin
      @(posedge clk);
      e++;
      #1 drive(e);
      @(negedge clk);
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (fin[i] && fin_seen[i] < 0) fin_seen[i] = e;
        if (e == ev_k[i] + 1) st_ev[i] = int'(st[i]);
        if (fin_seen[i] < 0) all_done = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_cyc = (ev_k[i] < CMAX[i]) ? ev_k[i] : CMAX[i];
      exp_st  = (cau_e[i] == 2 && DRN_T[i] > 0) ? 2 : 3;
      check($sformatf("%s d%0d finish edge", name, i), 64'(fin_seen[i]), 64'(fin_e[i]));
      check($sformatf("%s d%0d state after event", name, i), 64'(st_ev[i]), 64'(exp_st));
      check($sformatf("%s d%0d state", name, i), 64'(st[i]), 3);
      check($sformatf("%s d%0d finish", name, i), 64'(fin[i]), 1);
      check($sformatf("%s d%0d cause", name, i), 64'(cau[i]), 64'(cau_e[i]));
      check($sformatf("%s d%0d error", name, i), 64'(erro[i]), 64'(cau_e[i] == 2));
      check($sformatf("%s d%0d err_ch", name, i), 64'(errch[i]), 64'(ech_e[i]));
      check($sformatf("%s d%0d timed_out", name, i), 64'(tmo[i]), 64'(cau_e[i] == 3));
      check($sformatf("%s d%0d idle_ch", name, i), 64'(idlv[i]), 64'(iv_e[i]));
      check($sformatf("%s d%0d cycles", name, i), 64'(cyc_of(i)), 64'(exp_cyc));
    end
  endtask

  task automatic scen(input int n);
    clear_stim();
    case (n)
      1: ;  // nothing happens: timeouts only
      2: begin
        for (int k = 0; k < MAXK; k++) s_prog[k] = 2'b11;
        s_err[3] = 2'b10;
      end
      3: begin
        for (int k = 0; k < MAXK; k++) s_prog[k] = 2'b11;
        s_halt[4] = 2'b01;
        for (int k = 7; k < MAXK; k++) s_halt[k] = 2'b10;
      end
      4: for (int k = 0; k < MAXK; k++) s_prog[k] = 2'b01;
      5: begin
        for (int k = 0; k < MAXK; k++) s_prog[k] = 2'b01;
        s_halt[0] = 2'b10;
      end
      6: begin
        s_err[10]  = 2'b01;
        s_halt[10] = 2'b11;
      end
      default: for (int k = 0; k < MAXK; k++) s_prog[k] = 2'b11;
    endcase
  endtask

  task automatic gen_random();
    int dens, hs, ek;
    clear_stim();
    dens = $urandom_range(0, 4);
    for (int k = 0; k < MAXK; k++)
      for (int c = 0; c < 2; c++)
        s_prog[k][c] = ($urandom_range(0, 3) < dens);
    for (int c = 0; c < 2; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        hs = $urandom_range(0, 40);
        if ($urandom_range(0, 1) == 1) begin
          for (int k = hs; k < MAXK; k++) s_halt[k][c] = 1'b1;
        end else begin
          s_halt[hs][c] = 1'b1;
        end
      end
    end
    if ($urandom_range(0, 2) == 0) begin
      ek = $urandom_range(0, 50);
      s_err[ek] = 2'($urandom_range(1, 3));
    end
  endtask

  task automatic mid_drain_reset();
    scen(2);
    start_run();
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1 drive(e);
    end
    @(negedge clk);
    check("middrain d0 in drain", 64'(st[0]), 2);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("middrain d%0d state", i), 64'(st[i]), 0);
      check($sformatf("middrain d%0d finish", i), 64'(fin[i]), 0);
      check($sformatf("middrain d%0d error", i), 64'(erro[i]), 0);
      check($sformatf("middrain d%0d cycles", i), 64'(cyc_of(i)), 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL sim_limit: time limit reached, got no summary expected summary");
    $fatal(1, "time limit");
  end

  initial begin
    do_reset("init");
    for (int n = 1; n <= 7; n++) begin
      scen(n);
      do_run($sformatf("scen%0d", n));
      do_reset($sformatf("scen%0d", n));
    end
    mid_drain_reset();
    scen(1);
    do_run("rerun1");
    do_reset("rerun1");
    for (int r = 0; r < 20; r++) begin
      gen_random();
      do_run($sformatf("rand%0d", r));
      do_reset($sformatf("rand%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
